sound_cmd_mailbox: RTL

- Synchronous main-CPU → sound-CPU command mailbox. Sits directly upstream of the sound CPU bus; replaces the EPORT-clocked latches with a clean 48 MHz single-clock design.
- Latches 8-bit commands from the main CPU and presents them to the sound CPU at 0x5000. Presents pending/NMI-enable status at 0x5001.
- Generates a timed NMI pulse to the sound CPU and returns a one-byte reply with handshake flags to the main CPU.

---
 rtl/sound_pkg.sv | 33 +++
 rtl/strobe_edge.sv | 24 ++
 rtl/sound_cmd_mailbox.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the main-CPU -> sound-CPU command mailbox.
package sound_pkg;

   // NMI sequencer states
   typedef enum logic [1:0] {
      NMI_IDLE   = 2'd0,
      NMI_ASSERT = 2'd1,
      NMI_WAIT   = 2'd2
   } nmi_state_t;

   // Default NMI low width: 2 us at 48 MHz
   localparam int DEF_NMI_PULSE_LEN = 96;

   // Sound-side status byte (0x5001) bit positions
   localparam int SND_ST_PEND_BIT  = 3;
   localparam int SND_ST_NMIEN_BIT = 2;

   // Main-side status byte bit positions
   localparam int MAIN_ST_RVLD_BIT = 1;
   localparam int MAIN_ST_PEND_BIT = 0;

   // Assemble the sound-side status byte
   function automatic logic [7:0] snd_status_byte(input logic [3:0] hi,
                                                  input logic pend,
                                                  input logic en);
      logic [7:0] b;
      b = {hi, 4'b0011};
      b[SND_ST_PEND_BIT]  = pend;
      b[SND_ST_NMIEN_BIT] = en;
      return b;
   endfunction

endpackage

// File: rtl/strobe_edge.sv
// Registered edge detector for a bus strobe. One history flop; the edge
// pulse is valid in the cycle the new level is first sampled, so the
// action it gates lands on the following clock edge.
module strobe_edge #(
   parameter bit   RISE    = 1'b1,  // 1: detect rising edge, 0: falling
   parameter logic RST_LVL = 1'b0   // inactive level of the strobe
) (
   input  logic clkm_48MHZ,
   input  logic SB2RST,
   input  logic i_strobe,
   output logic o_edge
);

   logic r_prev;

   // Strobe history, reset to the inactive level so reset never fakes an edge
   always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
      if (!SB2RST) r_prev <= RST_LVL;
      else         r_prev <= i_strobe;
   end

   assign o_edge = RISE ? (i_strobe & ~r_prev) : (~i_strobe & r_prev);

endmodule

// File: rtl/sound_cmd_mailbox.sv
// Main-CPU -> sound-CPU command mailbox with timed NMI and reply byte.
module sound_cmd_mailbox
   import sound_pkg::*;
#(
   parameter int         NMI_PULSE_LEN = DEF_NMI_PULSE_LEN,  // 1..255
   parameter logic [3:0] STATUS_HI     = 4'hF
) (
   input  logic       clkm_48MHZ,
   input  logic       SB2RST,
   input  logic       main_cmd_wr,
   input  logic       main_ctl_wr,
   input  logic       main_rep_rd,
   input  logic [7:0] main_din,
   input  logic       snd_cmd_rd_n,
   input  logic       snd_rep_wr_n,
   input  logic [7:0] snd_din,
   input  logic       nmi_mask,
   output logic [7:0] cmd_data,
   output logic [7:0] snd_status,
   output logic [7:0] main_reply,
   output logic [7:0] main_status,
   output logic       snd_nmi_n,
   output logic       overrun
);

   localparam logic [7:0] CNT_LOAD = 8'(NMI_PULSE_LEN - 1);

   logic w_cmd_wr_edge, w_ctl_wr_edge, w_rep_rd_edge;
   logic w_snd_rd_edge, w_snd_wr_edge;

   logic [7:0] r_cmd_data, r_main_reply, r_cnt;
   logic       r_cmd_pending, r_nmi_en, r_reply_valid, r_overrun, r_snd_nmi_n;
   nmi_state_t r_state;

   strobe_edge #(.RISE(1'b1), .RST_LVL(1'b0)) u_cmd_wr (
      .clkm_48MHZ(clkm_48MHZ), .SB2RST(SB2RST), .i_strobe(main_cmd_wr),  .o_edge(w_cmd_wr_edge));
   strobe_edge #(.RISE(1'b1), .RST_LVL(1'b0)) u_ctl_wr (
      .clkm_48MHZ(clkm_48MHZ), .SB2RST(SB2RST), .i_strobe(main_ctl_wr),  .o_edge(w_ctl_wr_edge));
   strobe_edge #(.RISE(1'b0), .RST_LVL(1'b0)) u_rep_rd (
      .clkm_48MHZ(clkm_48MHZ), .SB2RST(SB2RST), .i_strobe(main_rep_rd),  .o_edge(w_rep_rd_edge));
   strobe_edge #(.RISE(1'b1), .RST_LVL(1'b1)) u_snd_rd (
      .clkm_48MHZ(clkm_48MHZ), .SB2RST(SB2RST), .i_strobe(snd_cmd_rd_n), .o_edge(w_snd_rd_edge));
   strobe_edge #(.RISE(1'b1), .RST_LVL(1'b1)) u_snd_wr (
      .clkm_48MHZ(clkm_48MHZ), .SB2RST(SB2RST), .i_strobe(snd_rep_wr_n), .o_edge(w_snd_wr_edge));

   // Command latch and pending flag; a write beats a same-cycle sound read
   always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
      if (!SB2RST) begin
         r_cmd_data    <= 8'h00;
         r_cmd_pending <= 1'b0;
      end else if (w_cmd_wr_edge) begin
         r_cmd_data    <= main_din;
         r_cmd_pending <= 1'b1;
      end else if (w_snd_rd_edge) begin
         r_cmd_pending <= 1'b0;
      end
   end

   // Sticky overrun: only a write onto a byte nobody is consuming this cycle
   always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
      if (!SB2RST)
         r_overrun <= 1'b0;
      else if (w_cmd_wr_edge && r_cmd_pending && !w_snd_rd_edge)
         r_overrun <= 1'b1;
      else if (w_ctl_wr_edge && main_din[7])
         r_overrun <= 1'b0;
   end

   // Control register: NMI enable
   always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
      if (!SB2RST)            r_nmi_en <= 1'b0;
      else if (w_ctl_wr_edge) r_nmi_en <= main_din[0];
   end

   // Reply latch and valid flag; a write beats a same-cycle main read
   always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
      if (!SB2RST) begin
         r_main_reply  <= 8'h00;
         r_reply_valid <= 1'b0;
      end else if (w_snd_wr_edge) begin
         r_main_reply  <= snd_din;
         r_reply_valid <= 1'b1;
      end else if (w_rep_rd_edge) begin
         r_reply_valid <= 1'b0;
      end
   end

   // NMI sequencer: one full-width pulse per command, re-armed when pending clears
   always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
      if (!SB2RST) begin
         r_state     <= NMI_IDLE;
         r_cnt       <= 8'd0;
         r_snd_nmi_n <= 1'b1;
      end else begin
         case (r_state)
            NMI_IDLE: begin
               r_snd_nmi_n <= 1'b1;
               if (r_cmd_pending && r_nmi_en && !nmi_mask) begin
                  r_state     <= NMI_ASSERT;
                  r_cnt       <= CNT_LOAD;
                  r_snd_nmi_n <= 1'b0;
               end
            end
            NMI_ASSERT: begin
               // enable/mask changes are ignored here so the pulse is never cut short
               if (r_cnt == 8'd0) begin
                  r_state     <= NMI_WAIT;
                  r_snd_nmi_n <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt - 8'd1;
                  r_snd_nmi_n <= 1'b0;
               end
            end
            NMI_WAIT: begin
               r_snd_nmi_n <= 1'b1;
               if (!r_cmd_pending) r_state <= NMI_IDLE;
            end
            default: begin
               r_state     <= NMI_IDLE;
               r_snd_nmi_n <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_data   = r_cmd_data;
   assign main_reply = r_main_reply;
   assign snd_nmi_n  = r_snd_nmi_n;
   assign overrun    = r_overrun;
   assign snd_status = snd_status_byte(STATUS_HI, r_cmd_pending, r_nmi_en);

   // Main-side status assembled from flags
   always_comb begin
      main_status                   = 8'h00;
      main_status[MAIN_ST_RVLD_BIT] = r_reply_valid;
      main_status[MAIN_ST_PEND_BIT] = r_cmd_pending;
   end

endmodule
